// File: rtl/id_scoreboard.sv
// Decode-stage hazard controller: per-register pending-write counters that
// stall the ID instruction on RAW hazards and on counter saturation.
module id_scoreboard #(
    parameter int unsigned CNT_W     = 2,
    parameter bit          WB_BYPASS = 1'b0,
    parameter int unsigned PERF_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              INSTR_VALID_ID,
    input  logic [6:0]        OPCODE,
    input  logic [4:0]        RS1_ID,
    input  logic [4:0]        RS2_ID,
    input  logic [4:0]        RD_ID,
    input  logic              RegWrite_ID,
    input  logic              RegWrite_WB,
    input  logic [4:0]        RD_WB,
    input  logic              FLUSH,
    output logic              STALL_ID,
    output logic              ISSUE_ID,
    output logic              SB_ERR,
    output logic [PERF_W-1:0] STALL_CNT
);

    localparam int unsigned    NREG    = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [CNT_W-1:0] pend [NREG];

    logic uses_rs1_c, uses_rs2_c;
    logic busy1_c, busy2_c;
    logic raw_c, full_c, live_c;
    logic inc_c, dec_c;

    // Which source fields the opcode actually reads; unknown opcodes read rs1 only
    always_comb begin
        uses_rs1_c = 1'b1;
        uses_rs2_c = 1'b0;
        case (OPCODE)
            OP_LUI, OP_AUIPC, OP_JAL:      uses_rs1_c = 1'b0;
            OP_RTYPE, OP_STORE, OP_BRANCH: uses_rs2_c = 1'b1;
            default: ;
        endcase
    end

    // Busy sources; with write-through, the last pending write retiring now frees the source
    always_comb begin
        busy1_c = (RS1_ID != 5'd0) && (pend[RS1_ID] != '0);
        busy2_c = (RS2_ID != 5'd0) && (pend[RS2_ID] != '0);
        if (WB_BYPASS && RegWrite_WB && (RD_WB == RS1_ID) && (pend[RS1_ID] == CNT_W'(1)))
            busy1_c = 1'b0;
        if (WB_BYPASS && RegWrite_WB && (RD_WB == RS2_ID) && (pend[RS2_ID] == CNT_W'(1)))
            busy2_c = 1'b0;
    end

    // Hazard evaluation; a same-cycle retire of RD_ID makes room in a saturated counter
    always_comb begin
        live_c = INSTR_VALID_ID & ~FLUSH;
        raw_c  = (uses_rs1_c & busy1_c) | (uses_rs2_c & busy2_c);
        full_c = RegWrite_ID && (RD_ID != 5'd0) && (pend[RD_ID] == CNT_MAX)
                 && !(RegWrite_WB && (RD_WB == RD_ID));
        inc_c  = ISSUE_ID & RegWrite_ID & (RD_ID != 5'd0);
        dec_c  = RegWrite_WB & (RD_WB != 5'd0);
    end

    assign STALL_ID = live_c & (raw_c | full_c);
    assign ISSUE_ID = live_c & ~(raw_c | full_c);

    // Pending-write counters; inc and dec on the same register cancel, dec never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) pend[i] <= '0;
        end else begin
            for (int i = 1; i < int'(NREG); i++) begin
                if (inc_c && (RD_ID == 5'(i)) && !(dec_c && (RD_WB == 5'(i))))
                    pend[i] <= pend[i] + CNT_W'(1);
                else if (dec_c && (RD_WB == 5'(i)) && !(inc_c && (RD_ID == 5'(i)))
                         && (pend[i] != '0))
                    pend[i] <= pend[i] - CNT_W'(1);
            end
        end
    end

    // Sticky flag for a retirement with nothing outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            SB_ERR <= 1'b0;
        else if (dec_c && (pend[RD_WB] == '0))
            SB_ERR <= 1'b1;
    end

    // Stall-cycle performance counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            STALL_CNT <= '0;
        else if (STALL_ID)
            STALL_CNT <= STALL_CNT + PERF_W'(1);
    end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
Scoreboard-based hazard controller for the decode stage.
- Tracks outstanding register writes between issue from ID and retirement at WB, and stalls the ID instruction while any source register it reads has a pending write.
- Gates IF/ID advance and ID/EX insertion, replacing a forwarding network in the no-bypass pipeline configuration.
- Also keeps a stall-cycle performance counter and a sticky protocol-error flag.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter (maximum in-flight writes per register = 2^CNT_W-1).
- WB_BYPASS, 0, 1 = a same-cycle WB retirement of the last pending write clears the hazard for that cycle (the register file writes through); 0 = conservative.
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- INSTR_VALID_ID  in  1  ID holds a valid instruction
- OPCODE  in  7  ID instruction[6:0]
- RS1_ID  in  5  source register 1
- RS2_ID  in  5  source register 2
- RD_ID  in  5  destination register
- RegWrite_ID  in  1  ID instruction writes RD_ID
- RegWrite_WB  in  1  WB stage writes register file
- RD_WB  in  5  WB destination
- FLUSH  in  1  squash the ID instruction (taken branch/jump resolved downstream)
- STALL_ID  out  1  hold PC and IF/ID; insert bubble into ID/EX
- ISSUE_ID  out  1  ID instruction advances to EX this cycle
- SB_ERR  out  1  sticky: WB retired a register with zero pending count
- STALL_CNT  out  PERF_W  number of cycles STALL_ID was high

Behaviour:
- State: pend[1..31], each CNT_W bits. Register x0 is never tracked; rd=0 and RD_WB=0 are ignored.
- Reset: all pend = 0, SB_ERR = 0, STALL_CNT = 0. The combinational outputs then give STALL_ID = 0 and ISSUE_ID = INSTR_VALID_ID & ~FLUSH. Reset takes effect immediately and asynchronously; in-flight tracking is lost by design, because the whole pipeline resets together.
- Source use decode from OPCODE:
  - uses_rs1 = 1 except for LUI 0110111, AUIPC 0010111, JAL 1101111.
  - uses_rs2 = 1 only for R-type 0110011, STORE 0100011, BRANCH 1100011.
  - Unknown opcodes: uses_rs1 = 1, uses_rs2 = 0.
- busy(r) = (r != 0) & (pend[r] != 0).
- When WB_BYPASS = 1, busy(r) is additionally masked when RegWrite_WB & RD_WB == r & pend[r] == 1.
- Hazard conditions:
  - raw = (uses_rs1 & busy(RS1_ID)) | (uses_rs2 & busy(RS2_ID)).
  - full = RegWrite_ID & RD_ID != 0 & pend[RD_ID] == max & ~(RegWrite_WB & RD_WB == RD_ID). This is a structural stall: the counter must never saturate silently.
- Output equations (combinational from state and inputs, no latency):
  - STALL_ID = INSTR_VALID_ID & ~FLUSH & (raw | full).
  - ISSUE_ID = INSTR_VALID_ID & ~FLUSH & ~(raw | full).
- FLUSH has priority over stall: a squashed instruction neither stalls nor issues and increments nothing.
- Per-cycle update, at the clk rising edge:
  - inc = ISSUE_ID & RegWrite_ID & RD_ID != 0.
  - dec = RegWrite_WB & RD_WB != 0.
  - inc and dec on the same register: pend unchanged (net zero).
  - inc and dec on different registers: both applied.
  - dec with pend[RD_WB] == 0: pend stays 0 (no wrap) and SB_ERR is set to 1 until reset.
- STALL_CNT increments by 1 each cycle STALL_ID = 1 and wraps modulo 2^PERF_W.
- WAW hazards need no stall: in-order retirement is guaranteed by the pipeline, and the counters handle multiple outstanding writes to one register.
- A stalled instruction re-evaluates every cycle with no hold state inside the block. ID inputs are stable while STALL_ID is high because STALL_ID freezes IF/ID.

Test Plan:
- Reset mid-operation: pend[5] = 2, assert rst_n = 0 asynchronously → STALL_ID, SB_ERR and STALL_CNT read 0 before the next edge; ADD x6,x5,x0 issues immediately after release.
- RAW stall and retire: issue ADDI x5 (pend[5] = 1), then present ADD x7,x5,x1 → STALL_ID = 1 until RegWrite_WB with RD_WB = 5.
  - WB_BYPASS = 0: ISSUE_ID = 1 on the cycle after retirement.
  - WB_BYPASS = 1: ISSUE_ID = 1 on the retirement cycle.
  - STALL_CNT equals the number of stalled cycles.
- Source decode: with pend[5] = 1, LUI x8 and JAL x1 with rs1 field = 5 issue without stall; SW x5,0(x2) stalls; ADDI x9,x2 with rs2 field = 5 does not stall.
- x0 handling: ADDI x0,x0,1 issued leaves all pend at 0; RegWrite_WB with RD_WB = 0 does not set SB_ERR; a source of x0 never stalls.
- Saturation with CNT_W = 2: three issues writing x3 → pend[3] = 3; fourth writer stalls (full); WB retire of x3 on the same cycle lets it issue with pend[3] remaining 3.
- FLUSH and error: FLUSH = 1 on a would-stall instruction → STALL_ID = 0, ISSUE_ID = 0, pend unchanged; WB retire of x10 with pend[10] = 0 → SB_ERR = 1 and stays set.
